mrr_sweep_scheduler: RTL and testbench

Sequences mode-register-read (MRR) commands across DRAM ranks behind the APB slave port. It consumes the periodic `mr_rd_pulse` from the slave's interval timer and the per-rank software MRR requests (`rank_mrr_o`). It issues one-at-a-time MRR requests to the DRAM command path and waits for per-rank done status. Software requests take priority over the periodic sweep; overruns and unresponsive ranks are flagged.

---
 rtl/mrr_sweep_scheduler_if.sv | 38 +++
 rtl/mrr_sweep_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mrr_sweep_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mrr_sweep_scheduler_if.sv
// mrr_sweep_scheduler_if
//   Groups the trigger, request/done and status signals of the MRR sweep
//   scheduler. Clock and reset stay as plain ports on the scheduler.
//   master : drives triggers, software requests, rank mask and done status
//   slave  : the scheduler; drives MRR requests, acks and status pulses
//
//   mr_rd_pulse_i  periodic sweep trigger (single cycle)
//   sw_mrr_req_i   per-rank software MRR request level
//   rank_en_i      populated-rank mask
//   mrr_done_i     per-rank done pulse from the command path
//   mrr_req_o      one-hot MRR request
//   sw_mrr_ack_o   per-rank software request completion pulse
//   busy_o         scheduler has work in flight or pending
//   overrun_o      trigger arrived while a sweep was still pending
//   timeout_o      selected rank failed to respond
interface mrr_sweep_scheduler_if #(
   parameter int NB_RANK = 2
);
   logic               mr_rd_pulse_i;
   logic [NB_RANK-1:0] sw_mrr_req_i;
   logic [NB_RANK-1:0] rank_en_i;
   logic [NB_RANK-1:0] mrr_done_i;
   logic [NB_RANK-1:0] mrr_req_o;
   logic [NB_RANK-1:0] sw_mrr_ack_o;
   logic               busy_o;
   logic               overrun_o;
   logic               timeout_o;

   modport master (
      output mr_rd_pulse_i, sw_mrr_req_i, rank_en_i, mrr_done_i,
      input  mrr_req_o, sw_mrr_ack_o, busy_o, overrun_o, timeout_o
   );

   modport slave (
      input  mr_rd_pulse_i, sw_mrr_req_i, rank_en_i, mrr_done_i,
      output mrr_req_o, sw_mrr_ack_o, busy_o, overrun_o, timeout_o
   );
endinterface

// File: rtl/mrr_sweep_scheduler.sv
// mrr_sweep_scheduler
//   Issues mode-register-read requests to DRAM ranks one at a time. Software
//   requests (rising edges of sw_mrr_req_i) are served before the periodic
//   sweep loaded by mr_rd_pulse_i. Each request is held until the selected
//   rank reports done, followed by one idle gap cycle.
//
//   Ports:
//     pclk_i   clock, rising edge
//     prst_ni  synchronous active-low reset
//     bus      mrr_sweep_scheduler_if.slave (triggers, requests, status)
//
//   Build option:
//     MRR_TIMEOUT_EN  when defined, a saturating WAIT-cycle counter aborts a
//                     request after TMO_CYC cycles and pulses timeout_o.
//                     When undefined, WAIT lasts until done and timeout_o is 0.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | pick lowest pending rank (software set first), raise request
//   WAIT  | request held, waiting for done (or timeout)
//   GAP   | one idle cycle between requests
module mrr_sweep_scheduler #(
   parameter int NB_RANK = 2,
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input logic                  pclk_i,
   input logic                  prst_ni,
   mrr_sweep_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             state;
   logic [NB_RANK-1:0] sw_q;
   logic [NB_RANK-1:0] sw_pend;
   logic [NB_RANK-1:0] sweep_pend;
   logic [NB_RANK-1:0] req_q;
   logic [NB_RANK-1:0] ack_q;
   logic               src_sw;
   logic               overrun_q;

   logic [NB_RANK-1:0] sw_rise;
   logic [NB_RANK-1:0] clr_sw;
   logic [NB_RANK-1:0] clr_sweep;
   logic [NB_RANK-1:0] trig_set;
   logic               done_hit;
   logic               req_end;

`ifdef MRR_TIMEOUT_EN
   logic [TMO_W-1:0]   tmo_cnt;
   logic [TMO_W-1:0]   tmo_nxt;
   logic               tmo_hit;
   logic               timeout_q;
`endif

   // Isolate the lowest set bit: v & (two's complement of v).
   function automatic logic [NB_RANK-1:0] lowest(input logic [NB_RANK-1:0] v);
      lowest = v & (~v + NB_RANK'(1));
   endfunction

   always_comb begin
      sw_rise  = bus.sw_mrr_req_i & ~sw_q;
      trig_set = bus.mr_rd_pulse_i ? bus.rank_en_i : '0;
      // Done bits of ranks that are not currently requested are ignored.
      done_hit = (state == ST_WAIT) && ((bus.mrr_done_i & req_q) != '0);
`ifdef MRR_TIMEOUT_EN
      tmo_nxt  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
      // Done in the same cycle as the limit wins over the timeout.
      tmo_hit  = (state == ST_WAIT) && !done_hit && (tmo_nxt == TMO_W'(TMO_CYC));
      req_end  = done_hit || tmo_hit;
`else
      req_end  = done_hit;
`endif
      // Only the pending set that sourced the request is cleared; a rank
      // served for software stays queued for the sweep.
      clr_sw    = (req_end &&  src_sw) ? req_q : '0;
      clr_sweep = (req_end && !src_sw) ? req_q : '0;
   end

   always_ff @(posedge pclk_i) begin
      if (!prst_ni) begin
         state      <= ST_IDLE;
         sw_q       <= '0;
         sw_pend    <= '0;
         sweep_pend <= '0;
         req_q      <= '0;
         ack_q      <= '0;
         src_sw     <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef MRR_TIMEOUT_EN
         tmo_cnt    <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         sw_q       <= bus.sw_mrr_req_i;
         // New sets override a same-cycle clear.
         sw_pend    <= (sw_pend & ~clr_sw) | sw_rise;
         sweep_pend <= (sweep_pend & ~clr_sweep) | trig_set;
         overrun_q  <= bus.mr_rd_pulse_i && (sweep_pend != '0);
         ack_q      <= '0;
`ifdef MRR_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (sw_pend != '0) begin
                  req_q  <= lowest(sw_pend);
                  src_sw <= 1'b1;
                  state  <= ST_WAIT;
`ifdef MRR_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end else if (sweep_pend != '0) begin
                  req_q  <= lowest(sweep_pend);
                  src_sw <= 1'b0;
                  state  <= ST_WAIT;
`ifdef MRR_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            ST_WAIT: begin
               if (done_hit) begin
                  req_q <= '0;
                  if (src_sw) ack_q <= req_q;
                  state <= ST_GAP;
               end
`ifdef MRR_TIMEOUT_EN
               else if (tmo_hit) begin
                  req_q     <= '0;
                  timeout_q <= 1'b1;
                  if (src_sw) ack_q <= req_q;
                  state     <= ST_GAP;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
`endif
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.mrr_req_o    = req_q;
   assign bus.sw_mrr_ack_o = ack_q;
   assign bus.overrun_o    = overrun_q;
   assign bus.busy_o       = (state != ST_IDLE) || (sw_pend != '0) || (sweep_pend != '0);
`ifdef MRR_TIMEOUT_EN
   assign bus.timeout_o    = timeout_q;
`else
   assign bus.timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mrr_sweep_scheduler.sv
// tb_mrr_sweep_scheduler
//   Directed bench for mrr_sweep_scheduler (NB_RANK=2, TMO_CYC=200).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
//   Build with MRR_TIMEOUT_EN defined to exercise the timeout path.
module tb_mrr_sweep_scheduler;

   logic pclk_i = 1'b0;
   logic prst_ni;

   int n_checks = 0;
   int n_fail   = 0;

   mrr_sweep_scheduler_if #(.NB_RANK(2)) bus ();

   mrr_sweep_scheduler #(
      .NB_RANK (2),
      .TMO_W   (8),
      .TMO_CYC (200)
   ) dut (
      .pclk_i  (pclk_i),
      .prst_ni (prst_ni),
      .bus     (bus)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk_i);
      #1;
   endtask

   task automatic pulse_trig();
      bus.mr_rd_pulse_i = 1'b1;
      tick();
      bus.mr_rd_pulse_i = 1'b0;
   endtask

   task automatic give_done(input logic [1:0] r);
      bus.mrr_done_i = r;
      tick();
      bus.mrr_done_i = 2'b00;
   endtask

   initial begin
      prst_ni           = 1'b0;
      bus.mr_rd_pulse_i = 1'b0;
      bus.sw_mrr_req_i  = 2'b00;
      bus.rank_en_i     = 2'b11;
      bus.mrr_done_i    = 2'b00;

      // Reset state
      tick(); tick();
      check_val("rst_req",     8'(bus.mrr_req_o),    8'h0);
      check_val("rst_ack",     8'(bus.sw_mrr_ack_o), 8'h0);
      check_val("rst_busy",    8'(bus.busy_o),       8'h0);
      check_val("rst_overrun", 8'(bus.overrun_o),    8'h0);
      check_val("rst_timeout", 8'(bus.timeout_o),    8'h0);
      prst_ni = 1'b1;
      tick();

      // Basic sweep of both ranks, done 3 cycles after each request
      pulse_trig();
      check_val("t1_req_k",   8'(bus.mrr_req_o), 8'h0);
      check_val("t1_busy_k",  8'(bus.busy_o),    8'h1);
      check_val("t1_ovr_k",   8'(bus.overrun_o), 8'h0);
      tick();
      check_val("t1_req0",    8'(bus.mrr_req_o), 8'h1);
      bus.mrr_done_i = 2'b10;  // done of non-selected rank is ignored
      tick();
      bus.mrr_done_i = 2'b00;
      check_val("t1_ignore",  8'(bus.mrr_req_o), 8'h1);
      tick();
      give_done(2'b01);
      check_val("t1_drop0",   8'(bus.mrr_req_o),    8'h0);
      check_val("t1_noack0",  8'(bus.sw_mrr_ack_o), 8'h0);
      tick();
      check_val("t1_gap",     8'(bus.mrr_req_o), 8'h0);
      tick();
      check_val("t1_req1",    8'(bus.mrr_req_o), 8'h2);
      tick(); tick();
      give_done(2'b10);
      check_val("t1_drop1",   8'(bus.mrr_req_o), 8'h0);
      check_val("t1_busy_gap",8'(bus.busy_o),    8'h1);
      tick();
      check_val("t1_idle",    8'(bus.busy_o),    8'h0);

      // Software request for rank 1 arriving during the sweep of rank 0
      pulse_trig();
      tick();
      check_val("t2_req0",    8'(bus.mrr_req_o), 8'h1);
      bus.sw_mrr_req_i = 2'b10;
      tick(); tick();
      give_done(2'b01);
      check_val("t2_noack0",  8'(bus.sw_mrr_ack_o), 8'h0);
      tick(); tick();
      check_val("t2_sw_req1", 8'(bus.mrr_req_o), 8'h2);
      tick();
      give_done(2'b10);
      check_val("t2_ack1",    8'(bus.sw_mrr_ack_o), 8'h2);
      tick();
      check_val("t2_ack_once",8'(bus.sw_mrr_ack_o), 8'h0);
      check_val("t2_busy",    8'(bus.busy_o),       8'h1);
      tick();
      check_val("t2_sweep1",  8'(bus.mrr_req_o), 8'h2);
      give_done(2'b10);
      check_val("t2_noack1",  8'(bus.sw_mrr_ack_o), 8'h0);
      tick();
      check_val("t2_idle",    8'(bus.busy_o), 8'h0);
      bus.sw_mrr_req_i = 2'b00;
      tick();

      // Overrun: second trigger while rank 1 still pending in the sweep
      pulse_trig();
      tick();
      check_val("t3_req0",    8'(bus.mrr_req_o), 8'h1);
      give_done(2'b01);
      pulse_trig();
      check_val("t3_overrun", 8'(bus.overrun_o), 8'h1);
      tick();
      check_val("t3_ovr_once",8'(bus.overrun_o), 8'h0);
      check_val("t3_resweep0",8'(bus.mrr_req_o), 8'h1);
      give_done(2'b01);
      tick(); tick();
      check_val("t3_resweep1",8'(bus.mrr_req_o), 8'h2);
      give_done(2'b10);
      tick();
      check_val("t3_idle",    8'(bus.busy_o),    8'h0);
      check_val("t3_ovr_end", 8'(bus.overrun_o), 8'h0);

      // Rank 1 never responds
      bus.rank_en_i = 2'b10;
      pulse_trig();
      tick();
      check_val("t4_req1",    8'(bus.mrr_req_o), 8'h2);
`ifdef MRR_TIMEOUT_EN
      repeat (199) tick();
      check_val("t4_hold199", 8'(bus.mrr_req_o), 8'h2);
      check_val("t4_no_tmo",  8'(bus.timeout_o), 8'h0);
      tick();
      check_val("t4_timeout", 8'(bus.timeout_o), 8'h1);
      check_val("t4_drop",    8'(bus.mrr_req_o), 8'h0);
      tick();
      check_val("t4_tmo_once",8'(bus.timeout_o), 8'h0);
      check_val("t4_idle",    8'(bus.busy_o),    8'h0);
`else
      repeat (250) tick();
      check_val("t4_hold",    8'(bus.mrr_req_o), 8'h2);
      check_val("t4_no_tmo",  8'(bus.timeout_o), 8'h0);
      give_done(2'b10);
      check_val("t4_drop",    8'(bus.mrr_req_o), 8'h0);
      tick();
      check_val("t4_idle",    8'(bus.busy_o),    8'h0);
`endif

      // Software request, done arriving on the 200th WAIT cycle
      bus.sw_mrr_req_i = 2'b10;
      tick();
      tick();
      check_val("t5_req1",    8'(bus.mrr_req_o), 8'h2);
      repeat (199) tick();
      give_done(2'b10);
      check_val("t5_no_tmo",  8'(bus.timeout_o),    8'h0);
      check_val("t5_drop",    8'(bus.mrr_req_o),    8'h0);
      check_val("t5_ack",     8'(bus.sw_mrr_ack_o), 8'h2);
      tick();
      check_val("t5_idle",    8'(bus.busy_o),       8'h0);
      bus.sw_mrr_req_i = 2'b00;
      bus.rank_en_i    = 2'b11;
      tick();

      // Reset for one cycle during WAIT
      pulse_trig();
      tick();
      check_val("t6_req0",    8'(bus.mrr_req_o), 8'h1);
      prst_ni = 1'b0;
      tick();
      check_val("t6_rst_req", 8'(bus.mrr_req_o),    8'h0);
      check_val("t6_rst_ack", 8'(bus.sw_mrr_ack_o), 8'h0);
      check_val("t6_rst_busy",8'(bus.busy_o),       8'h0);
      check_val("t6_rst_tmo", 8'(bus.timeout_o),    8'h0);
      prst_ni = 1'b1;
      tick(); tick();
      check_val("t6_discard", 8'(bus.mrr_req_o), 8'h0);
      check_val("t6_nobusy",  8'(bus.busy_o),    8'h0);
      pulse_trig();
      tick();
      check_val("t6_restart", 8'(bus.mrr_req_o), 8'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
